zone_pump_scheduler: RTL and testbench

- Shares the single irrigation pump between N_ZONES field zones using round-robin grants.
- Each grant is sequenced through prime, irrigate and flush phases, timed in 1 Hz ticks; the tank is refilled whenever it is not full.
- Sits between irrigation_state / pesticide_verification (request qualifiers) and lines_control / display (valve, pump and countdown consumers).

---
 rtl/zone_pump_scheduler_pkg.sv | 25 ++
 rtl/zone_pump_scheduler_rr_arbiter.sv | 31 +++
 rtl/zone_pump_scheduler.sv | 148 ++++++++++++++
 tb/tb_zone_pump_scheduler.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/zone_pump_scheduler_pkg.sv
// Shared definitions for the zone pump scheduler: FSM states, irrigation
// type codes and a one-hot helper.
package irrig_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PRIME    = 3'd1,
    IRRIGATE = 3'd2,
    FLUSH    = 3'd3,
    FILL     = 3'd4
  } state_t;

  localparam logic [1:0] TYPE_NONE      = 2'b00;
  localparam logic [1:0] TYPE_DRIP      = 2'b01;
  localparam logic [1:0] TYPE_SPRINKLER = 2'b10;

  // Indices at or beyond n give an all-zero vector.
  function automatic logic [7:0] to_onehot(input logic [2:0] index, input int unsigned n);
    logic [7:0] oh;
    oh = 8'd1 << index;
    if (32'(index) >= n) oh = '0;
    return oh;
  endfunction

endpackage

// File: rtl/zone_pump_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after the
// pointer, wrapping around.
module rr_arbiter
  import irrig_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0] req,
  input  logic [2:0]   pointer,
  output logic         grant_valid,
  output logic [2:0]   grant_idx
);

  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

  int unsigned p;

  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    p           = 0;
    for (int unsigned i = 0; i < N; i++) begin
      p = (32'(pointer) + i) % N;
      if (!grant_valid && req[IW'(p)]) begin
        grant_valid = 1'b1;
        grant_idx   = 3'(p);
      end
    end
  end

endmodule

// File: rtl/zone_pump_scheduler.sv
// Shares one irrigation pump between zones: round-robin grant, then
// prime / irrigate / flush phases timed in 1 Hz ticks; refills the tank.
module zone_pump_scheduler
  import irrig_pkg::*;
#(
  parameter int N_ZONES        = 4,
  parameter int PRIME_SECS     = 1,
  parameter int DRIP_SECS      = 10,
  parameter int SPRINKLER_SECS = 6,
  parameter int FLUSH_SECS     = 2,
  parameter int CNT_W          = 5
) (
  input  logic               clk_50mhz,
  input  logic               reset,
  input  logic               tick_1hz,
  input  logic [N_ZONES-1:0] zone_req,
  input  logic [1:0]         irrigation_type,
  input  logic               pesticide_ok,
  input  logic               tank_full,
  output logic [N_ZONES-1:0] valve_en,
  output logic               pump_on,
  output logic               fill_on,
  output logic               busy,
  output logic [2:0]         active_zone,
  output logic [CNT_W-1:0]   secs_left,
  output logic               alert_np
);

  localparam logic [CNT_W-1:0] PRIME_LEN = CNT_W'((PRIME_SECS < 1) ? 1 : PRIME_SECS);
  localparam logic [CNT_W-1:0] DRIP_LEN  = CNT_W'((DRIP_SECS < 1) ? 1 : DRIP_SECS);
  localparam logic [CNT_W-1:0] SPRK_LEN  = CNT_W'((SPRINKLER_SECS < 1) ? 1 : SPRINKLER_SECS);
  localparam logic [CNT_W-1:0] FLUSH_LEN = CNT_W'((FLUSH_SECS < 1) ? 1 : FLUSH_SECS);

  state_t             state, state_n;
  logic [2:0]         zone_q, zone_n;
  logic [1:0]         type_q, type_n;
  logic [2:0]         rr_q, rr_n;
  logic [CNT_W-1:0]   cnt_n;
  logic               alert_n;
  logic [N_ZONES-1:0] valve_n;
  logic [2:0]         active_n;
  logic               in_grant, type_ok, expire, abort;
  logic               grant_valid;
  logic [2:0]         grant_idx;

  rr_arbiter #(.N(N_ZONES)) u_arb (
    .req         (zone_req),
    .pointer     (rr_q),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  assign type_ok = (irrigation_type == TYPE_DRIP) || (irrigation_type == TYPE_SPRINKLER);
  assign expire  = tick_1hz && (secs_left <= CNT_W'(1));
  // valve_en holds onehot(zone) while irrigating, so it doubles as the zone mask
  assign abort   = ~|(zone_req & valve_en) || !tank_full || !pesticide_ok;

  always_comb begin
    state_n = state;
    zone_n  = zone_q;
    type_n  = type_q;
    rr_n    = rr_q;
    cnt_n   = secs_left;
    alert_n = 1'b0;
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (!tank_full) begin
          state_n = FILL;
        end else if (grant_valid && type_ok && pesticide_ok) begin
          state_n = PRIME;
          zone_n  = grant_idx;
          type_n  = irrigation_type;
          cnt_n   = PRIME_LEN;
        end else if (grant_valid && type_ok) begin
          alert_n = 1'b1;
        end
      end
      PRIME: begin
        if (expire) begin
          state_n = IRRIGATE;
          cnt_n   = (type_q == TYPE_SPRINKLER) ? SPRK_LEN : DRIP_LEN;
        end else if (tick_1hz) begin
          cnt_n = secs_left - CNT_W'(1);
        end
      end
      IRRIGATE: begin
        if (abort || expire) begin
          state_n = FLUSH;
          cnt_n   = FLUSH_LEN;
        end else if (tick_1hz) begin
          cnt_n = secs_left - CNT_W'(1);
        end
      end
      FLUSH: begin
        if (expire) begin
          rr_n    = (zone_q == 3'(N_ZONES - 1)) ? '0 : zone_q + 3'd1;
          state_n = tank_full ? IDLE : FILL;
          cnt_n   = '0;
        end else if (tick_1hz) begin
          cnt_n = secs_left - CNT_W'(1);
        end
      end
      FILL: begin
        cnt_n = '0;
        if (tank_full) state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase

    // Outputs are decoded from the next state so they register alongside it
    in_grant = (state_n == PRIME) || (state_n == IRRIGATE) || (state_n == FLUSH);
    valve_n  = in_grant ? N_ZONES'(to_onehot(zone_n, N_ZONES)) : '0;
    active_n = in_grant ? zone_n : '0;
  end

  always_ff @(posedge clk_50mhz or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      zone_q      <= '0;
      type_q      <= TYPE_NONE;
      rr_q        <= '0;
      valve_en    <= '0;
      pump_on     <= 1'b0;
      fill_on     <= 1'b0;
      busy        <= 1'b0;
      active_zone <= '0;
      secs_left   <= '0;
      alert_np    <= 1'b0;
    end else begin
      state       <= state_n;
      zone_q      <= zone_n;
      type_q      <= type_n;
      rr_q        <= rr_n;
      valve_en    <= valve_n;
      pump_on     <= (state_n == IRRIGATE);
      fill_on     <= (state_n == FILL);
      busy        <= (state_n != IDLE);
      active_zone <= active_n;
      secs_left   <= cnt_n;
      alert_np    <= alert_n;
    end
  end

endmodule

// File: tb/tb_zone_pump_scheduler.sv
// Self-checking bench for zone_pump_scheduler: directed scenarios plus
// randomized traffic against a phase-plan reference model.
module tb_zone_pump_scheduler;

  localparam int N  = 4;
  localparam int PS = 1;
  localparam int DS = 10;
  localparam int SS = 6;
  localparam int FS = 2;
  localparam int CW = 5;

  logic          clk_50mhz = 1'b0;
  logic          reset = 1'b0;
  logic          tick_1hz = 1'b0;
  logic [N-1:0]  zone_req = '0;
  logic [1:0]    irrigation_type = '0;
  logic          pesticide_ok = 1'b0;
  logic          tank_full = 1'b0;
  logic [N-1:0]  valve_en;
  logic          pump_on, fill_on, busy, alert_np;
  logic [2:0]    active_zone;
  logic [CW-1:0] secs_left;

  zone_pump_scheduler #(
    .N_ZONES(N), .PRIME_SECS(PS), .DRIP_SECS(DS), .SPRINKLER_SECS(SS),
    .FLUSH_SECS(FS), .CNT_W(CW)
  ) dut (
    .clk_50mhz(clk_50mhz), .reset(reset), .tick_1hz(tick_1hz),
    .zone_req(zone_req), .irrigation_type(irrigation_type),
    .pesticide_ok(pesticide_ok), .tank_full(tank_full),
    .valve_en(valve_en), .pump_on(pump_on), .fill_on(fill_on), .busy(busy),
    .active_zone(active_zone), .secs_left(secs_left), .alert_np(alert_np)
  );

  always #10 clk_50mhz = ~clk_50mhz;

  // Reference model: a granted zone owns a plan of (phase kind, ticks left)
  // entries; 1 = prime, 2 = irrigate, 3 = flush. Mode 0 idle, 1 fill, 2 serving.
  typedef struct {int kind; int len;} ph_t;
  ph_t plan[$];
  int  m_mode = 0, m_zone = 0, m_ptr = 0;
  bit  m_alert = 0;

  int n_checks = 0, n_fail = 0;
  int tick_div = 0, cyc = 0;

  function automatic int at_least1(input int v);
    return (v < 1) ? 1 : v;
  endfunction

  task automatic model_step();
    bit tok;
    tok = (irrigation_type == 2'b01) || (irrigation_type == 2'b10);
    m_alert = 0;
    case (m_mode)
      0: begin
        if (!tank_full) m_mode = 1;
        else if (zone_req != 0 && tok && pesticide_ok) begin
          for (int k = 0; k < N; k++) begin
            int z;
            z = (m_ptr + k) % N;
            if (zone_req[z]) begin m_zone = z; break; end
          end
          plan.delete();
          plan.push_back('{1, at_least1(PS)});
          plan.push_back('{2, at_least1(irrigation_type == 2'b10 ? SS : DS)});
          plan.push_back('{3, at_least1(FS)});
          m_mode = 2;
        end else if (zone_req != 0 && tok) m_alert = 1;
      end
      1: if (tank_full) m_mode = 0;
      default: begin
        if (plan[0].kind == 2 && (!zone_req[m_zone] || !tank_full || !pesticide_ok))
          void'(plan.pop_front());
        else if (tick_1hz) begin
          if (plan[0].len == 1) void'(plan.pop_front());
          else plan[0].len--;
        end
        if (plan.size() == 0) begin
          m_ptr  = (m_zone + 1) % N;
          m_mode = tank_full ? 0 : 1;
        end
      end
    endcase
  endtask

  always @(posedge clk_50mhz or posedge reset) begin
    if (reset) begin
      m_mode = 0; m_zone = 0; m_ptr = 0; m_alert = 0; plan.delete();
    end else model_step();
  end

  function automatic bit m_in(input int kind);
    return (m_mode == 2) && (plan.size() > 0) && (plan[0].kind == kind);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic compare_all();
    logic [31:0] ev;
    ev = (m_mode == 2) ? (32'd1 << m_zone) : 32'd0;
    chk("valve_en", 32'(valve_en), ev);
    chk("pump_on", 32'(pump_on), 32'(m_in(2)));
    chk("fill_on", 32'(fill_on), 32'(m_mode == 1));
    chk("busy", 32'(busy), 32'(m_mode != 0));
    chk("active_zone", 32'(active_zone), (m_mode == 2) ? 32'(m_zone) : 32'd0);
    chk("secs_left", 32'(secs_left), (m_mode == 2) ? 32'(plan[0].len) : 32'd0);
    chk("alert_np", 32'(alert_np), 32'(m_alert));
    chk("valve_onehot", 32'($countones(valve_en) <= 1), 32'd1);
    chk("pump_fill_excl", 32'(pump_on & fill_on), 32'd0);
  endtask

  task automatic cycle();
    @(negedge clk_50mhz);
    compare_all();
    cyc++;
    if (tick_div == 0) tick_1hz = 1'b0;
    else if (tick_div < 0) tick_1hz = ($urandom_range(0, 2) == 0);
    else tick_1hz = ((cyc % tick_div) == 0);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    #1;
    chk("rst_valve", 32'(valve_en), 32'd0);
    chk("rst_pump", 32'(pump_on), 32'd0);
    chk("rst_fill", 32'(fill_on), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_zone", 32'(active_zone), 32'd0);
    chk("rst_secs", 32'(secs_left), 32'd0);
    chk("rst_alert", 32'(alert_np), 32'd0);
    @(negedge clk_50mhz);
    reset = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    int grants[$];
    logic [N-1:0] prev_valve;

    #5 reset = 1'b1;
    @(negedge clk_50mhz);
    pulse_reset();

    // Single drip grant on zone 1, then pointer must sit at 2
    tank_full = 1; pesticide_ok = 1; irrigation_type = 2'b01; zone_req = 4'b0010; tick_div = 2;
    cycle();
    chk("s1_grant_latency", 32'(valve_en), 32'b0010);
    chk("s1_prime_pump_off", 32'(pump_on), 32'd0);
    for (t = 0; t < 100 && !m_in(2); t++) cycle();
    chk("s1_wait_irr", 32'(t < 100), 32'd1);
    chk("s1_irr_len", 32'(secs_left), 32'd10);
    chk("s1_irr_pump", 32'(pump_on), 32'd1);
    for (t = 0; t < 200 && !m_in(3); t++) cycle();
    chk("s1_wait_flush", 32'(t < 200), 32'd1);
    zone_req = '0;
    for (t = 0; t < 100 && m_mode != 0; t++) cycle();
    chk("s1_wait_idle", 32'(t < 100), 32'd1);
    zone_req = 4'b1111;
    cycle();
    chk("s1_pointer", 32'(active_zone), 32'd2);
    cycle();
    pulse_reset();  // lands mid-PRIME

    // All zones requesting sprinkler: round-robin from pointer 0
    irrigation_type = 2'b10; zone_req = 4'b1111; tick_div = 2;
    prev_valve = '0;
    for (t = 0; t < 2000 && grants.size() < 5; t++) begin
      cycle();
      if (valve_en != 0 && prev_valve == 0) grants.push_back(int'(active_zone));
      prev_valve = valve_en;
    end
    chk("s2_grant_count", 32'(grants.size()), 32'd5);
    for (int i = 0; i < grants.size(); i++) chk("s2_rr_order", 32'(grants[i]), 32'(i % 4));
    pulse_reset();

    // Pesticide block, then release
    zone_req = 4'b0100; irrigation_type = 2'b01; pesticide_ok = 0; tank_full = 1;
    repeat (4) cycle();
    chk("s3_alert", 32'(alert_np), 32'd1);
    chk("s3_no_valve", 32'(valve_en), 32'd0);
    chk("s3_not_busy", 32'(busy), 32'd0);
    pesticide_ok = 1;
    cycle();
    chk("s3_alert_clear", 32'(alert_np), 32'd0);
    chk("s3_grant_z2", 32'(valve_en), 32'b0100);

    // Tank drop mid-irrigate aborts, flush, fill, re-grant
    for (t = 0; t < 200 && !(m_in(2) && plan[0].len == 4); t++) cycle();
    chk("s4_wait_secs4", 32'(t < 200), 32'd1);
    tank_full = 0;
    cycle();
    chk("s4_abort_pump", 32'(pump_on), 32'd0);
    chk("s4_flush_valve", 32'(valve_en), 32'b0100);
    chk("s4_flush_secs", 32'(secs_left), 32'd2);
    for (t = 0; t < 100 && m_mode != 1; t++) cycle();
    chk("s4_fill", 32'(fill_on), 32'd1);
    repeat (3) cycle();
    tank_full = 1;
    cycle();
    cycle();
    chk("s4_regrant", 32'(valve_en), 32'b0100);

    // Ticks every cycle: entry tick ignored; drop + expiry gives one flush
    pulse_reset();
    zone_req = 4'b0001; irrigation_type = 2'b10; tick_div = 1; tick_1hz = 1;
    cycle();
    chk("s5_entry_tick", 32'(secs_left), 32'd1);
    for (t = 0; t < 100 && !(m_in(2) && plan[0].len == 1); t++) cycle();
    chk("s5_wait_last", 32'(t < 100), 32'd1);
    zone_req = '0; tick_1hz = 1;
    cycle();
    chk("s5_flush_load", 32'(secs_left), 32'd2);
    chk("s5_flush_pump", 32'(pump_on), 32'd0);
    cycle();
    chk("s5_single_flush", 32'(secs_left), 32'd1);

    // Reset mid-FILL, then pointer back at 0
    tick_div = 2;
    for (t = 0; t < 100 && m_mode != 0; t++) cycle();
    tank_full = 0;
    repeat (3) cycle();
    chk("s6_fill", 32'(fill_on), 32'd1);
    pulse_reset();
    tank_full = 1; zone_req = 4'b1111; irrigation_type = 2'b01;
    cycle();
    chk("s6_ptr0_valve", 32'(valve_en), 32'b0001);
    chk("s6_ptr0_zone", 32'(active_zone), 32'd0);

    // Randomized traffic
    tick_div = -1;
    for (int i = 0; i < 3000; i++) begin
      cycle();
      if ($urandom_range(0, 7) == 0) zone_req = N'($urandom);
      if ($urandom_range(0, 15) == 0) irrigation_type = 2'($urandom);
      if ($urandom_range(0, 15) == 0) pesticide_ok = ($urandom_range(0, 6) != 0);
      if ($urandom_range(0, 15) == 0) tank_full = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 399) == 0) pulse_reset();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
